// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared state encodings, hold defaults and arbitration helper
package rr_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_t;

    localparam int DEFAULT_MAX_HOLD = 4;
    localparam int HOLD_W           = 4;

    // Rule A: a lone request wins; a tie goes to whoever was not granted last.
    function automatic arb_state_t rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return last ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
            return ST_GNT0;
        end else if (req1) begin
            return ST_GNT1;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// rtl/mux2_cell.sv - single-bit 2:1 mux cell
module mux2_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - WIDTH-bit 2:1 mux built from replicated single-bit cells
module mux2_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        mux2_cell u_cell (
            .i_a   (i_a[g]),
            .i_b   (i_b[g]),
            .i_sel (i_sel),
            .o_y   (o_y[g])
        );
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - two-requester round-robin arbiter with bounded hold and shared data mux
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             done,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             grant0,
    output logic             grant1,
    output logic             select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    logic              r_last;
    logic [HOLD_W-1:0] r_hold;

    arb_state_t        w_next_state;
    logic              w_next_last;
    logic [HOLD_W-1:0] w_next_hold;
    logic              w_owner;
    logic              w_req_own;
    logic              w_req_oth;
    logic              w_release;

    // Owner index is meaningful only in the GNT states.
    assign w_owner   = (r_state == ST_GNT1);
    assign w_req_own = w_owner ? req1 : req0;
    assign w_req_oth = w_owner ? req0 : req1;
    assign w_release = done || !w_req_own || (r_hold == HOLD_LAST);

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_next_hold  = r_hold;
        case (r_state)
            ST_IDLE: begin
                w_next_state = rr_pick(req0, req1, r_last);
                w_next_hold  = '0;
            end
            ST_GNT0, ST_GNT1: begin
                if (w_release) begin
                    w_next_last = w_owner;
                    w_next_hold = '0;
                    if (w_req_oth) begin
                        w_next_state = w_owner ? ST_GNT0 : ST_GNT1;
                    end else if (w_req_own) begin
                        w_next_state = r_state;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_hold = r_hold + 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_hold  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            r_hold  <= w_next_hold;
        end
    end

    // GNT0/GNT1 encodings are one-hot, so grants come straight off state flops.
    assign grant0    = (r_state == ST_GNT0);
    assign grant1    = (r_state == ST_GNT1);
    assign select    = grant1;
    assign out_valid = grant0 | grant1;

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_a   (data0),
        .i_b   (data1),
        .i_sel (select),
        .o_y   (out_data)
    );

endmodule
